// File: rtl/ipb_master_arbiter.sv
// Round-robin arbiter sharing one IPbus slave port between N_REQ single-word masters.
// Registered bus outputs, one-cycle ack/err routing to the winner, and a hung-access timeout.
module ipb_master_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                     ipb_clk,
  input  logic                     ipb_rst_n,
  input  logic [N_REQ-1:0]         req_strobe,
  input  logic [N_REQ-1:0]         req_write,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         req_ack,
  output logic [N_REQ-1:0]         req_err,
  output logic [DATA_W-1:0]        req_rdata,
  output logic [ADDR_W-1:0]        ipb_addr,
  output logic [DATA_W-1:0]        ipb_wdata,
  output logic                     ipb_strobe,
  output logic                     ipb_write,
  input  logic [DATA_W-1:0]        ipb_rdata,
  input  logic                     ipb_ack,
  input  logic                     ipb_err,
  output logic [N_REQ-1:0]         grant,
  output logic                     timeout
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [CNT_W-1:0]   cnt;
  logic [PTR_W-1:0]   win_idx;
  logic               win_found;
  logic [PTR_W-1:0]   next_ptr;
  logic [N_REQ-1:0]   win_mask;
  logic [N_REQ-1:0]   owner_mask;
  logic               finish;

  // First requesting index at or above rr_ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req_strobe[(int'(rr_ptr) + i) % N_REQ]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'((int'(rr_ptr) + i) % N_REQ);
      end
    end
  end

  assign next_ptr   = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
  assign win_mask   = N_REQ'(1) << win_idx;
  assign owner_mask = N_REQ'(1) << owner;
  // The final ACCESS cycle ends on a slave response or after TIMEOUT strobe cycles.
  assign finish     = ipb_err | ipb_ack | (cnt == CNT_LAST);

  always_ff @(posedge ipb_clk or negedge ipb_rst_n) begin
    if (!ipb_rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      cnt        <= '0;
      ipb_strobe <= 1'b0;
      ipb_write  <= 1'b0;
      ipb_addr   <= '0;
      ipb_wdata  <= '0;
      req_ack    <= '0;
      req_err    <= '0;
      req_rdata  <= '0;
      grant      <= '0;
      timeout    <= 1'b0;
    end else begin
      req_ack <= '0;
      req_err <= '0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            state      <= ACCESS;
            owner      <= win_idx;
            rr_ptr     <= next_ptr;
            cnt        <= '0;
            grant      <= win_mask;
            ipb_strobe <= 1'b1;
            ipb_write  <= req_write[win_idx];
            ipb_addr   <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
            ipb_wdata  <= req_wdata[int'(win_idx)*DATA_W +: DATA_W];
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (finish) begin
            state      <= DONE;
            ipb_strobe <= 1'b0;
            grant      <= '0;
            // Error beats ack when both arrive together; timeout only without a response.
            if (ipb_err) begin
              req_err <= owner_mask;
            end else if (ipb_ack) begin
              req_ack   <= owner_mask;
              req_rdata <= ipb_rdata;
            end else begin
              req_err <= owner_mask;
              timeout <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ipb_master_arbiter.sv
// Directed self-checking bench for ipb_master_arbiter (N_REQ=4, TIMEOUT=8).
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_ipb_master_arbiter;

  localparam int N_REQ   = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic                     ipb_clk;
  logic                     ipb_rst_n;
  logic [N_REQ-1:0]         req_strobe;
  logic [N_REQ-1:0]         req_write;
  logic [N_REQ*ADDR_W-1:0]  req_addr;
  logic [N_REQ*DATA_W-1:0]  req_wdata;
  logic [N_REQ-1:0]         req_ack;
  logic [N_REQ-1:0]         req_err;
  logic [DATA_W-1:0]        req_rdata;
  logic [ADDR_W-1:0]        ipb_addr;
  logic [DATA_W-1:0]        ipb_wdata;
  logic                     ipb_strobe;
  logic                     ipb_write;
  logic [DATA_W-1:0]        ipb_rdata;
  logic                     ipb_ack;
  logic                     ipb_err;
  logic [N_REQ-1:0]         grant;
  logic                     timeout;

  int checks = 0;
  int errors = 0;

  ipb_master_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .ipb_clk(ipb_clk), .ipb_rst_n(ipb_rst_n),
    .req_strobe(req_strobe), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .req_err(req_err), .req_rdata(req_rdata),
    .ipb_addr(ipb_addr), .ipb_wdata(ipb_wdata),
    .ipb_strobe(ipb_strobe), .ipb_write(ipb_write),
    .ipb_rdata(ipb_rdata), .ipb_ack(ipb_ack), .ipb_err(ipb_err),
    .grant(grant), .timeout(timeout)
  );

  initial ipb_clk = 1'b0;
  always #5 ipb_clk = ~ipb_clk;

  task automatic tick();
    @(posedge ipb_clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int idx, input logic strobe, input logic write,
                                input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    req_strobe[idx] = strobe;
    req_write[idx]  = write;
    req_addr[idx*ADDR_W +: ADDR_W]  = addr;
    req_wdata[idx*DATA_W +: DATA_W] = wdata;
  endtask

  int order [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    ipb_rst_n  = 1'b1;
    req_strobe = '0;
    req_write  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    ipb_rdata  = '0;
    ipb_ack    = 1'b0;
    ipb_err    = 1'b0;
    #2 ipb_rst_n = 1'b0;
    tick();
    tick();
    check_output("reset_strobe", 64'(ipb_strobe), 64'd0);
    check_output("reset_grant", 64'(grant), 64'd0);
    check_output("reset_ack_err", 64'({req_ack, req_err, timeout}), 64'd0);
    ipb_rst_n = 1'b1;

    // Slave ack while idle must not reach any requester.
    ipb_ack = 1'b1;
    tick();
    check_output("idle_ack_ignored", 64'(req_ack), 64'd0);
    ipb_ack = 1'b0;
    tick();

    $display("[TB] single read from requester 2");
    apply_stimulus(2, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    tick();
    check_output("read_grant", 64'(grant), 64'b0100);
    check_output("read_strobe1", 64'(ipb_strobe), 64'd1);
    check_output("read_addr", 64'(ipb_addr), 64'h10);
    check_output("read_write", 64'(ipb_write), 64'd0);
    check_output("read_rr_ptr", 64'(dut.rr_ptr), 64'd3);
    tick();
    check_output("read_strobe2", 64'(ipb_strobe), 64'd1);
    check_output("read_no_early_ack", 64'(req_ack), 64'd0);
    tick();
    check_output("read_strobe3", 64'(ipb_strobe), 64'd1);
    ipb_ack   = 1'b1;
    ipb_rdata = 32'hDEAD_BEEF;
    tick();
    check_output("read_ack", 64'(req_ack), 64'b0100);
    check_output("read_rdata", 64'(req_rdata), 64'hDEAD_BEEF);
    check_output("read_strobe_low", 64'(ipb_strobe), 64'd0);
    check_output("read_grant_clear", 64'(grant), 64'd0);
    ipb_ack = 1'b0;
    apply_stimulus(2, 1'b0, 1'b0, 32'h0000_0010, 32'h0);
    tick();
    check_output("read_ack_single", 64'(req_ack), 64'd0);

    $display("[TB] simultaneous ack and err");
    apply_stimulus(0, 1'b1, 1'b0, 32'h0000_0044, 32'h0);
    tick();
    check_output("ackerr_grant", 64'(grant), 64'b0001);
    ipb_ack   = 1'b1;
    ipb_err   = 1'b1;
    ipb_rdata = 32'h1111_1111;
    tick();
    check_output("ackerr_err", 64'(req_err), 64'b0001);
    check_output("ackerr_no_ack", 64'(req_ack), 64'd0);
    check_output("ackerr_rdata_kept", 64'(req_rdata), 64'hDEAD_BEEF);
    ipb_ack = 1'b0;
    ipb_err = 1'b0;
    apply_stimulus(0, 1'b0, 1'b0, 32'h0000_0044, 32'h0);
    tick();
    check_output("ackerr_err_single", 64'(req_err), 64'd0);

    $display("[TB] requester inputs change after grant");
    apply_stimulus(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    tick();
    check_output("hold_addr0", 64'(ipb_addr), 64'h40);
    apply_stimulus(0, 1'b0, 1'b1, 32'h0000_0080, 32'h5555_5555);
    tick();
    check_output("hold_addr1", 64'(ipb_addr), 64'h40);
    check_output("hold_strobe", 64'(ipb_strobe), 64'd1);
    check_output("hold_write", 64'(ipb_write), 64'd0);
    ipb_ack   = 1'b1;
    ipb_rdata = 32'hCAFE_0000;
    tick();
    check_output("hold_ack", 64'(req_ack), 64'b0001);
    check_output("hold_rdata", 64'(req_rdata), 64'hCAFE_0000);
    check_output("hold_addr_end", 64'(ipb_addr), 64'h40);
    ipb_ack = 1'b0;
    tick();

    $display("[TB] timeout on write from requester 1");
    apply_stimulus(1, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678);
    tick();
    check_output("to_grant", 64'(grant), 64'b0010);
    check_output("to_write", 64'(ipb_write), 64'd1);
    check_output("to_addr", 64'(ipb_addr), 64'h20);
    check_output("to_wdata", 64'(ipb_wdata), 64'h1234_5678);
    for (int c = 2; c <= TIMEOUT; c++) begin
      tick();
      check_output($sformatf("to_strobe_cycle%0d", c), 64'({ipb_strobe, timeout, req_err}), 64'b1_0_0000);
    end
    tick();
    check_output("to_strobe_low", 64'(ipb_strobe), 64'd0);
    check_output("to_timeout", 64'(timeout), 64'd1);
    check_output("to_err", 64'(req_err), 64'b0010);
    check_output("to_no_ack", 64'(req_ack), 64'd0);
    apply_stimulus(1, 1'b0, 1'b0, 32'h0000_0020, 32'h1234_5678);
    tick();
    check_output("to_pulse_end", 64'({timeout, req_err}), 64'd0);
    tick();
    check_output("to_idle_strobe", 64'(ipb_strobe), 64'd0);

    $display("[TB] reset during access");
    apply_stimulus(1, 1'b1, 1'b1, 32'h0000_00A0, 32'hA5A5_A5A5);
    tick();
    check_output("rst_pre_grant", 64'(grant), 64'b0010);
    ipb_rst_n = 1'b0;
    #1;
    check_output("rst_async_strobe", 64'(ipb_strobe), 64'd0);
    check_output("rst_async_grant", 64'(grant), 64'd0);
    check_output("rst_async_write", 64'(ipb_write), 64'd0);
    check_output("rst_async_addr", 64'(ipb_addr), 64'd0);
    check_output("rst_async_wdata", 64'(ipb_wdata), 64'd0);
    check_output("rst_async_rdata", 64'(req_rdata), 64'd0);
    check_output("rst_async_pulses", 64'({req_ack, req_err, timeout}), 64'd0);
    apply_stimulus(1, 1'b1, 1'b0, 32'h0000_00B0, 32'h0);
    apply_stimulus(2, 1'b1, 1'b0, 32'h0000_00C0, 32'h0);
    tick();
    check_output("rst_held_strobe", 64'(ipb_strobe), 64'd0);
    ipb_rst_n = 1'b1;
    tick();
    check_output("rst_first_grant", 64'(grant), 64'b0010);
    check_output("rst_first_addr", 64'(ipb_addr), 64'hB0);
    ipb_ack = 1'b1;
    tick();
    check_output("rst_first_ack", 64'(req_ack), 64'b0010);
    ipb_ack    = 1'b0;
    req_strobe = '0;
    tick();

    $display("[TB] round-robin fairness");
    ipb_rst_n = 1'b0;
    #2 ipb_rst_n = 1'b1;
    req_strobe = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_output($sformatf("rr_grant%0d", k), 64'(grant), 64'(4'b0001 << order[k]));
      ipb_ack = 1'b1;
      tick();
      check_output($sformatf("rr_ack%0d", k), 64'(req_ack), 64'(4'b0001 << order[k]));
      ipb_ack = 1'b0;
      req_strobe[order[k]] = 1'b0;
      tick();
      check_output($sformatf("rr_gap%0d", k), 64'(ipb_strobe), 64'd0);
      req_strobe[order[k]] = 1'b1;
    end
    req_strobe = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
